// File: rtl/usb_personality_router.sv
// Routes one USB beat stream to one of NUM_PERS protocol handlers and switches
// between them safely: drain the open packet, flush the output beat, reset both handlers.
module usb_personality_router #(
   parameter int NUM_PERS      = 5,
   parameter int DATA_W        = 32,
   parameter int DEFAULT_PERS  = 4,
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int RESET_CYCLES  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [2:0]               pers_sel,
   input  logic                     pers_switch,
   output logic                     switch_done,
   output logic                     switch_err,
   output logic                     switch_timeout,
   output logic                     switch_busy,
   output logic [2:0]               active_pers,
   output logic [2:0]               router_state,
   input  logic [DATA_W-1:0]        usb_rx_data,
   input  logic                     usb_rx_valid,
   output logic                     usb_rx_ready,
   output logic [DATA_W-1:0]        usb_tx_data,
   output logic                     usb_tx_last,
   output logic                     usb_tx_valid,
   input  logic                     usb_tx_ready,
   output logic [DATA_W-1:0]        pers_rx_data,
   output logic [NUM_PERS-1:0]      pers_rx_valid,
   input  logic [NUM_PERS-1:0]      pers_rx_ready,
   input  logic [NUM_PERS*DATA_W-1:0] pers_tx_data,
   input  logic [NUM_PERS-1:0]      pers_tx_last,
   input  logic [NUM_PERS-1:0]      pers_tx_valid,
   output logic [NUM_PERS-1:0]      pers_tx_ready,
   output logic [NUM_PERS-1:0]      pers_reset
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACTIVE = 3'd1,
      DRAIN  = 3'd2,
      FLUSH  = 3'd3,
      PRESET = 3'd4,
      SWITCH = 3'd5
   } state_t;

   localparam logic [2:0]  DEF_PERS  = 3'(DEFAULT_PERS);
   localparam logic [15:0] TMO_LOAD  = 16'(DRAIN_TIMEOUT);
   localparam logic [7:0]  RST_LOAD  = 8'(RESET_CYCLES - 1);

   state_t              state;
   logic [2:0]          pending;
   logic                in_packet;
   logic [15:0]         timer;
   logic [7:0]          rst_cnt;

   logic                tx_open;
   logic                timer_expire;
   logic                tx_load;
   logic                sel_tx_valid;
   logic                sel_tx_last;
   logic [DATA_W-1:0]   sel_tx_data;
   logic                sel_rx_ready;
   logic [NUM_PERS-1:0] act_onehot;
   logic [NUM_PERS-1:0] pend_onehot;

   always_comb begin
      sel_tx_valid = 1'b0;
      sel_tx_last  = 1'b0;
      sel_tx_data  = '0;
      sel_rx_ready = 1'b0;
      act_onehot   = '0;
      pend_onehot  = '0;
      for (int i = 0; i < NUM_PERS; i++) begin
         if (active_pers == 3'(i)) begin
            act_onehot[i] = 1'b1;
            sel_tx_valid  = pers_tx_valid[i];
            sel_tx_last   = pers_tx_last[i];
            sel_tx_data   = pers_tx_data[i*DATA_W +: DATA_W];
            sel_rx_ready  = pers_rx_ready[i];
         end
         if (pending == 3'(i)) begin
            pend_onehot[i] = 1'b1;
         end
      end
   end

   // The beat offered on the expiry cycle is refused, since the output register is dropped then.
   assign timer_expire  = (timer <= 16'd1);
   assign tx_open       = (state == ACTIVE) | ((state == DRAIN) & in_packet & ~timer_expire);
   assign tx_load       = sel_tx_valid & tx_open & (~usb_tx_valid | usb_tx_ready);
   assign pers_tx_ready = act_onehot & {NUM_PERS{(~usb_tx_valid | usb_tx_ready) & tx_open}};

   assign pers_rx_data  = usb_rx_data;
   assign pers_rx_valid = act_onehot & {NUM_PERS{usb_rx_valid & (state == ACTIVE)}};
   assign usb_rx_ready  = sel_rx_ready & (state == ACTIVE);

   assign switch_busy   = (state != ACTIVE);
   assign router_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         active_pers    <= DEF_PERS;
         pending        <= DEF_PERS;
         usb_tx_valid   <= 1'b0;
         usb_tx_last    <= 1'b0;
         usb_tx_data    <= '0;
         in_packet      <= 1'b0;
         timer          <= '0;
         rst_cnt        <= '0;
         switch_done    <= 1'b0;
         switch_err     <= 1'b0;
         switch_timeout <= 1'b0;
         pers_reset     <= '0;
      end else begin
         switch_done <= 1'b0;
         switch_err  <= 1'b0;

         if (tx_load) begin
            usb_tx_data  <= sel_tx_data;
            usb_tx_last  <= sel_tx_last;
            usb_tx_valid <= 1'b1;
            in_packet    <= ~sel_tx_last;
         end else if (usb_tx_ready) begin
            usb_tx_valid <= 1'b0;
         end

         // Later assignments in this case deliberately override the datapath updates above.
         case (state)
            IDLE: begin
               state <= ACTIVE;
            end
            ACTIVE: begin
               if (pers_switch) begin
                  if (int'(pers_sel) >= NUM_PERS) begin
                     switch_err <= 1'b1;
                  end else if (pers_sel == active_pers) begin
                     switch_done <= 1'b1;
                  end else begin
                     pending        <= pers_sel;
                     switch_timeout <= 1'b0;
                     timer          <= TMO_LOAD;
                     state          <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (timer != 16'd0) timer <= timer - 16'd1;
               if (timer_expire) begin
                  usb_tx_valid   <= 1'b0;
                  in_packet      <= 1'b0;
                  switch_timeout <= 1'b1;
                  pers_reset     <= act_onehot | pend_onehot;
                  rst_cnt        <= RST_LOAD;
                  state          <= PRESET;
               end else if (!in_packet || (tx_load && sel_tx_last)) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (timer != 16'd0) timer <= timer - 16'd1;
               if (!usb_tx_valid) begin
                  pers_reset <= act_onehot | pend_onehot;
                  rst_cnt    <= RST_LOAD;
                  state      <= PRESET;
               end else if (timer_expire) begin
                  usb_tx_valid   <= 1'b0;
                  in_packet      <= 1'b0;
                  switch_timeout <= 1'b1;
                  pers_reset     <= act_onehot | pend_onehot;
                  rst_cnt        <= RST_LOAD;
                  state          <= PRESET;
               end
            end
            PRESET: begin
               if (rst_cnt == 8'd0) begin
                  pers_reset <= '0;
                  state      <= SWITCH;
               end else begin
                  rst_cnt <= rst_cnt - 8'd1;
               end
            end
            SWITCH: begin
               active_pers <= pending;
               switch_done <= 1'b1;
               state       <= ACTIVE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/usb_personality_router.md
USB_PERSONALITY_ROUTER -- requirements
Module: usb_personality_router

Interface
REQ-001 SHALL have parameter NUM_PERS, default 5, meaning number of personalities (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, meaning USB beat width.
REQ-003 SHALL have parameter DEFAULT_PERS, default 4, meaning personality after reset.
REQ-004 SHALL have parameter DRAIN_TIMEOUT, default 1024, meaning maximum drain/flush cycles (16-bit).
REQ-005 SHALL have parameter RESET_CYCLES, default 4, meaning personality reset pulse length (1..255).
REQ-006 SHALL have ports, in order:
 clk  in  1  single clock;
 rst_n  in  1  asynchronous active-low reset;
 pers_sel  in  3  requested personality;
 pers_switch  in  1  switch request strobe;
 switch_done  out  1  one-cycle pulse, switch finished;
 switch_err  out  1  one-cycle pulse, request rejected;
 switch_timeout  out  1  sticky, last switch hit timeout;
 switch_busy  out  1  high when state is not ACTIVE;
 active_pers  out  3  current personality;
 router_state  out  3  state encoding;
 usb_rx_data  in  DATA_W  host-to-device beat;
 usb_rx_valid  in  1;  usb_rx_ready  out  1;
 usb_tx_data  out  DATA_W  registered;  usb_tx_last  out  1  registered;
 usb_tx_valid  out  1  registered;  usb_tx_ready  in  1;
 pers_rx_data  out  DATA_W  broadcast copy of usb_rx_data;
 pers_rx_valid  out  NUM_PERS;  pers_rx_ready  in  NUM_PERS;
 pers_tx_data  in  NUM_PERS*DATA_W  slot i at [i*DATA_W +: DATA_W];
 pers_tx_last  in  NUM_PERS;  pers_tx_valid  in  NUM_PERS;  pers_tx_ready  out  NUM_PERS;
 pers_reset  out  NUM_PERS  protocol-handler reset, active high.

Function
REQ-007 SHALL implement states IDLE=0, ACTIVE=1, DRAIN=2, FLUSH=3, PRESET=4, SWITCH=5; router_state SHALL equal the state register.
REQ-008 IDLE SHALL go to ACTIVE after one cycle with active_pers=DEFAULT_PERS.
REQ-009 RX path combinational: pers_rx_valid[i]=usb_rx_valid & ACTIVE & (i==active_pers); usb_rx_ready=pers_rx_ready[active_pers] & ACTIVE; all other pers_rx_valid bits 0.
REQ-010 TX path SHALL use a one-entry output register: pers_tx_ready[active]=(!usb_tx_valid | usb_tx_ready) & tx_open; inactive ready bits 0; beat loaded on pers_tx_valid & pers_tx_ready; usb_tx_valid cleared on usb_tx_ready with no new load; zero-bubble throughput 1 beat/cycle.
REQ-011 tx_open SHALL be 1 in ACTIVE, in_packet in DRAIN, 0 elsewhere.
REQ-012 in_packet SHALL set on accepted beat with last=0, clear on accepted beat with last=1.
REQ-013 In ACTIVE, pers_switch with pers_sel>=NUM_PERS SHALL pulse switch_err next cycle, remain ACTIVE.
REQ-014 In ACTIVE, pers_switch with pers_sel==active_pers SHALL pulse switch_done next cycle, remain ACTIVE.
REQ-015 In ACTIVE, valid differing pers_sel SHALL capture pending, clear switch_timeout, load timer=DRAIN_TIMEOUT, go DRAIN.
REQ-016 pers_switch outside ACTIVE SHALL be ignored (no pulse).
REQ-017 DRAIN: RX gated; go FLUSH when in_packet==0 (including same cycle a last beat is accepted).
REQ-018 FLUSH: go PRESET when usb_tx_valid==0.
REQ-019 Timer SHALL decrement each cycle in DRAIN/FLUSH; at 0 SHALL force PRESET, clear usb_tx_valid and in_packet, set switch_timeout.
REQ-020 PRESET SHALL assert pers_reset for old and pending personalities for exactly RESET_CYCLES cycles, then go SWITCH.
REQ-021 SWITCH SHALL set active_pers=pending, pulse switch_done, go ACTIVE (1 cycle).
REQ-022 Minimum switch latency with idle traffic: request to switch_done = RESET_CYCLES+4 cycles.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, active_pers=DEFAULT_PERS, pending=DEFAULT_PERS, usb_tx_valid=0, usb_tx_last=0, usb_tx_data=0, in_packet=0, timer=0, switch_done=0, switch_err=0, switch_timeout=0, pers_reset=0.
REQ-024 Reset mid-switch SHALL abandon the switch; active_pers returns to DEFAULT_PERS.

Verification
REQ-025 Post-reset: rst_n released -> router_state 0 then 1, active_pers=4, only pers_rx_valid[4] follows usb_rx_valid.
REQ-026 Idle switch 4->0 with RESET_CYCLES=4 -> pers_reset=5'b10001 for 4 cycles, switch_done 8 cycles after request, active_pers=0.
REQ-027 Mid-packet switch: personality 4 sending 6-beat packet, request after beat 2, usb_tx_ready=1 -> all 6 beats delivered, last beat has usb_tx_last=1, no beat of new packet accepted, then PRESET.
REQ-028 Timeout: DRAIN_TIMEOUT=16, usb_tx_ready held 0 with valid beat -> PRESET after 16 cycles, usb_tx_valid=0, switch_timeout=1.
REQ-029 pers_sel=7 with NUM_PERS=5 -> switch_err one cycle, state stays 1; pers_sel==active -> switch_done one cycle, no pers_reset.
REQ-030 Backpressure: usb_tx_ready toggling 1/0 -> no beat lost or duplicated, order preserved.
